// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART pattern generator and its transmit core.
//   - parity encodings (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - pattern mode encodings on the 2-bit mode input
//   - serialiser FSM state type
//   - clks_per_bit(): clock cycles per UART bit time
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Mode 3 is reserved and is folded onto MODE_FIXED by the top level
    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    // Integer division; the caller is expected to keep the result >= 4
    function automatic int clks_per_bit(input int clkFreq, input int baud);
        return clkFreq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Baud timing plus frame serialiser: start bit, DATA_BITS data bits (LSB
// first), optional parity bit, STOP_BITS stop bits and GAP_BITS idle bits.
//
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   start_i  request a frame; honoured only while idle
//   data_i   character captured when start_i is honoured
//   tx_o     registered serial output, idle high
//   busy_o   high from the first start cycle to the last stop/gap cycle
//   done_o   combinational strobe in the final cycle of the last stop/gap bit
// -----------------------------------------------------------------------------
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);
    import uart_pkg::*;

    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int MAX_BITS = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
    localparam int BIT_W    = $clog2(MAX_BITS + 1);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   lastBaud;
    logic                   dataXor;
    logic                   parBit;

    assign lastBaud = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    assign dataXor  = ^data_i;
    assign parBit   = (PARITY == PAR_EVEN) ? dataXor  :
                      (PARITY == PAR_ODD)  ? ~dataXor : 1'b0;

    // State, counters, shift register and the serial line are all registered
    // so tx never glitches; reset forces the line high straight away.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic. tx_d always carries the line level of the state being
    // entered, so the registered tx lines up exactly with the state register.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_o  = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = lastBaud ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (start_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                    par_d   = parBit;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (lastBaud) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (lastBaud) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (lastBaud) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (lastBaud) begin
                    tx_d = 1'b1;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (GAP_BITS > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                            done_o  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (lastBaud) begin
                    tx_d = 1'b1;
                    if (bit_q == BIT_W'(GAP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                        done_o  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o   = tx_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_pattern_gen.sv
// -----------------------------------------------------------------------------
// uart_pattern_gen
// Character-pattern source for serial bring-up. Synchronises the enable
// switch, chooses the next character (fixed, incrementing with wrap, or a
// bounded burst), counts completed frames and drives uart_tx_core.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          enable switch (asynchronous, synchronised here)
//   mode        0 fixed, 1 incrementing, 2 burst, 3 behaves as fixed
//   tx          UART serial output, idle high
//   busy        frame (including gap) in progress
//   frame_done  one-cycle pulse in the idle cycle that closes each frame
//   char_count  frames completed since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module uart_pattern_gen #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 0,
    parameter int START_CHAR = 32,
    parameter int END_CHAR   = 126,
    parameter int FIXED_CHAR = 65,
    parameter int BURST_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] char_count
);
    import uart_pkg::*;

    localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int         BURST_W      = $clog2(BURST_LEN + 1);
    localparam logic [7:0] CHAR_START   = 8'(START_CHAR);
    localparam logic [7:0] CHAR_END     = 8'(END_CHAR);
    localparam logic [7:0] CHAR_FIXED   = 8'(FIXED_CHAR);

    logic               enMeta_q, enSync_q, enPrev_q;
    logic [1:0]         modeLat_q, modeLat_d;
    logic [7:0]         char_q, char_d;
    logic [BURST_W-1:0] burstRem_q, burstRem_d;
    logic [15:0]        charCount_q, charCount_d;
    logic               frameDone_q;
    logic [1:0]         modeEff;
    logic               enRise;
    logic               launch;
    logic [7:0]         dataSel;
    logic               coreBusy;
    logic               coreDone;

    // Two-flop synchroniser for the switch, plus a third flop that remembers
    // the previous synchronised level so burst mode can see rising edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enMeta_q <= 1'b0;
            enSync_q <= 1'b0;
            enPrev_q <= 1'b0;
        end else begin
            enMeta_q <= en;
            enSync_q <= enMeta_q;
            enPrev_q <= enSync_q;
        end
    end

    // Reserved mode 3 is treated exactly like fixed mode.
    always_comb begin
        case (mode)
            MODE_INC:   modeEff = MODE_INC;
            MODE_BURST: modeEff = MODE_BURST;
            default:    modeEff = MODE_FIXED;
        endcase
    end

    assign enRise  = enSync_q && !enPrev_q;
    assign launch  = enSync_q && !coreBusy &&
                     ((modeEff != MODE_BURST) || (burstRem_q != '0));
    assign dataSel = (modeEff == MODE_FIXED) ? CHAR_FIXED : char_q;

    // Pattern bookkeeping. The character, burst budget and frame count all
    // update on the core's done strobe, so the idle cycle that follows a frame
    // already presents the next character to a back-to-back launch. A burst
    // is only reloaded once the previous one has run out.
    always_comb begin
        modeLat_d   = modeLat_q;
        char_d      = char_q;
        burstRem_d  = burstRem_q;
        charCount_d = charCount_q;

        if (launch) begin
            modeLat_d = modeEff;
        end

        if (coreDone) begin
            charCount_d = charCount_q + 16'd1;
            if (modeLat_q != MODE_FIXED) begin
                char_d = (char_q == CHAR_END) ? CHAR_START : char_q + 8'd1;
            end
            if ((modeLat_q == MODE_BURST) && (burstRem_q != '0)) begin
                burstRem_d = burstRem_q - 1'b1;
            end
        end

        if (enRise && (burstRem_q == '0)) begin
            burstRem_d = BURST_W'(BURST_LEN);
        end
    end

    // Pattern registers; frame_done is the core's strobe delayed one cycle so
    // it coincides with the updated count and the core's return to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modeLat_q   <= MODE_FIXED;
            char_q      <= CHAR_START;
            burstRem_q  <= '0;
            charCount_q <= 16'd0;
            frameDone_q <= 1'b0;
        end else begin
            modeLat_q   <= modeLat_d;
            char_q      <= char_d;
            burstRem_q  <= burstRem_d;
            charCount_q <= charCount_d;
            frameDone_q <= coreDone;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY),
        .STOP_BITS    (STOP_BITS),
        .GAP_BITS     (GAP_BITS)
    ) txCore (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (launch),
        .data_i  (dataSel[DATA_BITS-1:0]),
        .tx_o    (tx),
        .busy_o  (coreBusy),
        .done_o  (coreDone)
    );

    assign busy       = coreBusy;
    assign frame_done = frameDone_q;
    assign char_count = charCount_q;

endmodule

// File: tb/tb_uart_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_pattern_gen
// Directed bench for uart_pattern_gen at 16 clocks per bit. Instance A covers
// fixed / incrementing / burst patterns, enable drop and reset abort; a UART
// receiver model decodes A's line and compares each character against a
// queue of expected characters. Instances B (even parity, 2 stop, 3 gap) and
// C (odd parity) check parity levels and frame length.
// -----------------------------------------------------------------------------
module tb_uart_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enA;
    logic [1:0]  modeA;
    logic        txA, busyA, frameDoneA;
    logic [15:0] countA;
    logic        enP;
    logic [1:0]  modeP;
    logic        txB, busyB, doneB;
    logic [15:0] countB;
    logic        txC, busyC, doneC;
    logic [15:0] countC;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [7:0]  expQ[$];
    bit          abortFrame  = 1'b0;

    always #5 clk = ~clk;

    uart_pattern_gen #(
        .CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
        .GAP_BITS(0), .START_CHAR(125), .END_CHAR(126), .FIXED_CHAR(65),
        .BURST_LEN(3)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .en(enA), .mode(modeA), .tx(txA),
        .busy(busyA), .frame_done(frameDoneA), .char_count(countA)
    );

    uart_pattern_gen #(
        .CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
        .GAP_BITS(3), .START_CHAR(32), .END_CHAR(126), .FIXED_CHAR(65),
        .BURST_LEN(16)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .en(enP), .mode(modeP), .tx(txB),
        .busy(busyB), .frame_done(doneB), .char_count(countB)
    );

    uart_pattern_gen #(
        .CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
        .GAP_BITS(0), .START_CHAR(32), .END_CHAR(126), .FIXED_CHAR(65),
        .BURST_LEN(16)
    ) dutC (
        .clk(clk), .rst_n(rst_n), .en(enP), .mode(modeP), .tx(txC),
        .busy(busyC), .frame_done(doneC), .char_count(countC)
    );

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic enVal, input logic [1:0] modeVal);
        enA   = enVal;
        modeA = modeVal;
    endtask

    // Waits (bounded) for a start bit on A (sel 0) or B (sel 1).
    task automatic waitTxLow(input int sel, input string tag);
        logic seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            seen = (sel == 0) ? (txA === 1'b0) : (txB === 1'b0);
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic waitFrameDone(input string tag);
        logic seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            seen = (frameDoneA === 1'b1);
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic checkIdleA(input int cycles, input string tag);
        int bad = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (txA !== 1'b1 || busyA !== 1'b0) bad++;
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    // Receiver model on A: samples each bit mid-way and pops the scoreboard.
    // Frames cut short by a reset are flagged by the main sequence and dropped.
    initial begin
        logic [7:0] rx;
        logic [7:0] exp;
        logic       startBit, stopBit;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txA === 1'b0) begin
                rx = 8'h00;
                repeat (7) @(negedge clk);
                startBit = txA;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    rx[i] = txA;
                end
                repeat (16) @(negedge clk);
                stopBit = txA;
                if (abortFrame) begin
                    abortFrame = 1'b0;
                end else begin
                    checkOutput("rx_queue_nonempty", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) begin
                        exp = expQ.pop_front();
                        checkOutput("rx_char", 32'(rx), 32'(exp));
                        checkOutput("rx_start_bit", 32'(startBit), 32'd0);
                        checkOutput("rx_stop_bit", 32'(stopBit), 32'd1);
                    end
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        logic [9:0] lvl;
        rst_n = 1'b0;
        enP   = 1'b0;
        modeP = 2'd0;
        applyStimulus(1'b0, 2'd0);
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset_tx", 32'(txA), 32'd1);
        checkOutput("reset_busy", 32'(busyA), 32'd0);
        checkOutput("reset_frame_done", 32'(frameDoneA), 32'd0);
        checkOutput("reset_count", 32'(countA), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] fixed mode 'A' frame timing");
        lvl = {1'b1, 8'h41, 1'b0};
        expQ.push_back(8'h41);
        applyStimulus(1'b1, 2'd0);
        waitTxLow(0, "t1_start");
        applyStimulus(1'b0, 2'd0);
        for (int j = 0; j < 160; j++) begin
            if (j > 0) @(negedge clk);
            if (j % 16 == 0 || j % 16 == 15)
                checkOutput($sformatf("t1_level_%0d", j), 32'(txA), 32'(lvl[j/16]));
        end
        checkOutput("t1_busy_last", 32'(busyA), 32'd1);
        checkOutput("t1_done_early", 32'(frameDoneA), 32'd0);
        @(negedge clk);
        checkOutput("t1_done", 32'(frameDoneA), 32'd1);
        checkOutput("t1_busy_after", 32'(busyA), 32'd0);
        checkOutput("t1_count", 32'(countA), 32'd1);
        @(negedge clk);
        checkOutput("t1_done_pulse", 32'(frameDoneA), 32'd0);
        checkOutput("t1_queue", 32'(expQ.size()), 32'd0);

        $display("[TB] enable dropped mid-frame");
        expQ.push_back(8'h41);
        applyStimulus(1'b1, 2'd0);
        waitTxLow(0, "t5_start");
        repeat (50) @(negedge clk);
        applyStimulus(1'b0, 2'd0);
        waitFrameDone("t5_done");
        checkOutput("t5_count", 32'(countA), 32'd2);
        checkIdleA(300, "t5_no_restart");
        checkOutput("t5_queue", 32'(expQ.size()), 32'd0);

        $display("[TB] incrementing mode with wrap");
        expQ.push_back(8'h7D);
        expQ.push_back(8'h7E);
        expQ.push_back(8'h7D);
        expQ.push_back(8'h7E);
        applyStimulus(1'b1, 2'd1);
        waitFrameDone("t2_done1");
        waitFrameDone("t2_done2");
        waitFrameDone("t2_done3");
        applyStimulus(1'b0, 2'd1);
        waitFrameDone("t2_done4");
        checkOutput("t2_count", 32'(countA), 32'd6);
        checkIdleA(200, "t2_stopped");
        checkOutput("t2_queue", 32'(expQ.size()), 32'd0);

        $display("[TB] parity, two stop bits and gap");
        enP = 1'b1;
        waitTxLow(1, "t3_start");
        checkOutput("t3_c_start", 32'(txC), 32'd0);
        for (int j = 1; j <= 241; j++) begin
            @(negedge clk);
            case (j)
                152: begin
                    checkOutput("t3_even_parity", 32'(txB), 32'd0);
                    checkOutput("t3_odd_parity", 32'(txC), 32'd1);
                end
                168, 184: checkOutput($sformatf("t3_stop_%0d", j), 32'(txB), 32'd1);
                175: checkOutput("t3_c_busy_last", 32'(busyC), 32'd1);
                176: begin
                    checkOutput("t3_c_done", 32'(doneC), 32'd1);
                    checkOutput("t3_c_busy_after", 32'(busyC), 32'd0);
                end
                200, 216, 232: checkOutput($sformatf("t3_gap_%0d", j), 32'(txB), 32'd1);
                239: checkOutput("t3_b_busy_last", 32'(busyB), 32'd1);
                240: begin
                    checkOutput("t3_b_done", 32'(doneB), 32'd1);
                    checkOutput("t3_b_busy_after", 32'(busyB), 32'd0);
                end
                241: checkOutput("t3_b_next_start", 32'(txB), 32'd0);
                default: ;
            endcase
        end
        enP = 1'b0;
        repeat (400) @(negedge clk);
        checkOutput("t3_b_count", 32'(countB), 32'd2);
        checkOutput("t3_c_count", 32'(countC), 32'd2);
        checkOutput("t3_b_idle", 32'(busyB), 32'd0);
        checkOutput("t3_c_idle", 32'(busyC), 32'd0);

        $display("[TB] burst mode");
        expQ.push_back(8'h7D);
        expQ.push_back(8'h7E);
        expQ.push_back(8'h7D);
        applyStimulus(1'b1, 2'd2);
        waitFrameDone("t4_done1");
        waitFrameDone("t4_done2");
        waitFrameDone("t4_done3");
        checkIdleA(1000, "t4_burst_idle");
        checkOutput("t4_count", 32'(countA), 32'd9);
        checkOutput("t4_queue", 32'(expQ.size()), 32'd0);
        applyStimulus(1'b0, 2'd2);
        repeat (5) @(negedge clk);
        expQ.push_back(8'h7E);
        expQ.push_back(8'h7D);
        expQ.push_back(8'h7E);
        applyStimulus(1'b1, 2'd2);
        waitFrameDone("t4_done4");
        waitFrameDone("t4_done5");
        waitFrameDone("t4_done6");
        checkIdleA(300, "t4_burst_idle2");
        checkOutput("t4_count2", 32'(countA), 32'd12);
        checkOutput("t4_queue2", 32'(expQ.size()), 32'd0);
        applyStimulus(1'b0, 2'd2);
        repeat (5) @(negedge clk);

        $display("[TB] reset mid-frame");
        expQ.push_back(8'h7D);
        applyStimulus(1'b1, 2'd1);
        waitFrameDone("t6_first");
        checkOutput("t6_count_before", 32'(countA), 32'd13);
        waitTxLow(0, "t6_second_start");
        repeat (40) @(negedge clk);
        abortFrame = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_tx", 32'(txA), 32'd1);
        checkOutput("t6_reset_busy", 32'(busyA), 32'd0);
        checkOutput("t6_reset_count", 32'(countA), 32'd0);
        repeat (150) @(negedge clk);
        expQ.push_back(8'h7D);
        rst_n = 1'b1;
        waitTxLow(0, "t6_restart");
        applyStimulus(1'b0, 2'd1);
        waitFrameDone("t6_done");
        checkOutput("t6_count", 32'(countA), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("t6_queue", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
